// File: rtl/concat_array_serializer.sv
// Buffers one complete N-word array per handshake and streams it out one word
// per beat, element 0 first, with back-to-back frame capture on the last beat.
module concat_array_serializer #(
    parameter int WIDTH = 32,
    parameter int N = 15,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] I [N-1:0],
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O,
    output logic             O_valid,
    input  logic             O_ready,
    output logic [IW-1:0]    O_index,
    output logic             O_last
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           st;
    state_t           st_nxt;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_nxt;
    logic [WIDTH-1:0] frame_buf [N-1:0];

    logic capture;
    logic beat;
    logic at_last;

    assign at_last = (idx == LAST_IDX);
    assign O_valid = (st == SEND);
    assign O_last  = O_valid && at_last;
    assign O_index = idx;
    assign O       = frame_buf[idx];

    // The final accepted beat frees the buffer in the same cycle, so the next
    // frame can be taken without a bubble.
    assign I_ready = (st == IDLE) || (O_last && O_ready);

    assign capture = I_valid && I_ready;
    assign beat    = O_valid && O_ready;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            st  <= IDLE;
            idx <= '0;
        end else begin
            st  <= st_nxt;
            idx <= idx_nxt;
        end
    end

    // A capture while in SEND can only coincide with the last beat, so it
    // takes priority and restarts the index for the new frame.
    always_comb begin
        st_nxt  = st;
        idx_nxt = idx;
        if (capture) begin
            st_nxt  = SEND;
            idx_nxt = '0;
        end else if (beat) begin
            if (at_last) begin
                st_nxt  = IDLE;
                idx_nxt = '0;
            end else begin
                idx_nxt = idx + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            for (int k = 0; k < N; k++) begin
                frame_buf[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < N; k++) begin
                frame_buf[k] <= I[k];
            end
        end
    end

endmodule

// File: tb/tb_concat_array_serializer.sv
// Directed and randomized bench for concat_array_serializer, checked against a
// queue-of-expected-words model of the output stream.
module tb_concat_array_serializer;

    localparam int WIDTH = 32;
    localparam int N     = 15;
    localparam int IW    = (N > 1) ? $clog2(N) : 1;

    logic             CLK = 1'b0;
    logic             ASYNCRESET;
    logic [WIDTH-1:0] din [N-1:0];
    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] O;
    logic             O_valid;
    logic             O_ready;
    logic [IW-1:0]    O_index;
    logic             O_last;

    concat_array_serializer #(.WIDTH(WIDTH), .N(N)) dut (
        .CLK(CLK),
        .ASYNCRESET(ASYNCRESET),
        .I(din),
        .I_valid(I_valid),
        .I_ready(I_ready),
        .O(O),
        .O_valid(O_valid),
        .O_ready(O_ready),
        .O_index(O_index),
        .O_last(O_last)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [WIDTH-1:0] w;
        int               idx;
    } ent_t;

    ent_t q[$];
    int   passed = 0;
    int   total  = 0;
    int   vrun   = 0;
    int   vmax   = 0;
    int   ncap   = 0;
    logic cap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fill(input logic [WIDTH-1:0] base);
        for (int i = 0; i < N; i++) din[i] = base + WIDTH'(i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) din[i] = $urandom;
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, then
    // advance the model at the rising edge exactly as the stream rules dictate.
    task automatic step(input logic iv, input logic ordy, output logic c);
        logic ev;
        logic ir;
        logic bt;
        I_valid = iv;
        O_ready = ordy;
        @(negedge CLK);
        ev = (q.size() > 0);
        ir = (q.size() == 0) || (q.size() == 1 && ordy);
        chk("O_valid", 32'(O_valid), 32'(ev));
        chk("I_ready", 32'(I_ready), 32'(ir));
        if (ev) begin
            chk("O", O, q[0].w);
            chk("O_index", 32'(O_index), 32'(q[0].idx));
            chk("O_last", 32'(O_last), 32'(q[0].idx == N - 1));
        end else begin
            chk("O_index_idle", 32'(O_index), 32'd0);
            chk("O_last_idle", 32'(O_last), 32'd0);
        end
        if (O_valid === 1'b1) begin
            vrun++;
            if (vrun > vmax) vmax = vrun;
        end else begin
            vrun = 0;
        end
        c  = iv && ir;
        bt = ev && ordy;
        @(posedge CLK);
        if (bt) void'(q.pop_front());
        if (c) for (int i = 0; i < N; i++) q.push_back('{w: din[i], idx: i});
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_O_valid"}, 32'(O_valid), 32'd0);
        chk({tag, "_I_ready"}, 32'(I_ready), 32'd1);
        chk({tag, "_O"}, O, 32'd0);
        chk({tag, "_O_index"}, 32'(O_index), 32'd0);
        chk({tag, "_O_last"}, 32'(O_last), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ASYNCRESET = 1'b1;
        I_valid    = 1'b0;
        O_ready    = 1'b0;
        fill(32'h0);
        #2;
        reset_checks("rst_init");
        #10 ASYNCRESET = 1'b0;
        @(posedge CLK);
        #1;

        // Idle with I_valid low: nothing is emitted.
        for (int c = 0; c < 6; c++) step(1'b0, 1'($urandom_range(0, 1)), cap);

        // Single frame with O_ready held high.
        fill(32'h100);
        vmax = 0;
        step(1'b1, 1'b1, cap);
        fill_rand();
        for (int c = 1; c <= 17; c++) step(1'b0, 1'b1, cap);
        chk("single_valid_run", 32'(vmax), 32'd15);

        // Backpressure in cycles 3-5; upstream data changes during streaming.
        fill(32'h100);
        vmax = 0;
        step(1'b1, 1'b1, cap);
        for (int c = 1; c <= 20; c++) begin
            fill_rand();
            step(1'b0, !(c >= 3 && c <= 5), cap);
        end
        chk("bp_valid_run", 32'(vmax), 32'd18);

        // Back-to-back frames A and B with I_valid continuous.
        fill(32'hA00);
        vmax = 0;
        ncap = 0;
        for (int c = 0; c < 40; c++) begin
            step(ncap < 2, 1'b1, cap);
            if (cap) begin
                ncap++;
                if (ncap == 1) fill(32'hB00);
            end
        end
        chk("b2b_captures", 32'(ncap), 32'd2);
        chk("b2b_valid_run", 32'(vmax), 32'd30);

        // Reset pulse after beat 7 of a frame, then a fresh frame C.
        fill_rand();
        step(1'b1, 1'b1, cap);
        for (int c = 0; c < 8; c++) step(1'b0, 1'b1, cap);
        #2 ASYNCRESET = 1'b1;
        #1 reset_checks("rst_mid");
        q.delete();
        #2 ASYNCRESET = 1'b0;
        @(posedge CLK);
        #1;
        fill(32'hC00);
        step(1'b1, 1'b1, cap);
        for (int c = 0; c < 18; c++) step(1'b0, 1'b1, cap);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) fill_rand();
            step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0), cap);
        end

        // Drain, then hold I_valid low.
        for (int c = 0; c < 40; c++) step(1'b0, 1'b1, cap);
        for (int c = 0; c < 10; c++) step(1'b0, 1'($urandom_range(0, 1)), cap);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
